// File: rtl/legv8_insn_encoder.sv
// Purpose : packs symbolic LEGv8 instructions into 32-bit words and streams them into instruction memory.
// Latency : request accepted at edge N -> wr_en (or err) high for the whole cycle after edge N.
// Backpressure: req_ready low while a request is being emitted, while full, or while clear is asserted.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   req_valid/req_ready     request handshake
//   op, rd, rn, rm, imm,    symbolic instruction fields (rd doubles as Rt)
//   shamt
//   clear                   synchronous restart of address and word count
//   wr_en/wr_addr/wr_data   instruction-memory write port (byte address)
//   err/err_code            rejection pulse and sticky reason (1 op, 2 imm, 3 shamt)
//   count/full              words written, count == DEPTH
module legv8_insn_encoder #(
  parameter int ADDR_W    = 10,
  parameter int DEPTH     = 256,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        op,
  input  logic [4:0]        rd,
  input  logic [4:0]        rn,
  input  logic [4:0]        rm,
  input  logic [25:0]       imm,
  input  logic [5:0]        shamt,
  input  logic              clear,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W-1:0] count,
  output logic              full
);

  localparam logic [3:0] OP_ADDI = 4'd0;
  localparam logic [3:0] OP_ADDS = 4'd1;
  localparam logic [3:0] OP_B    = 4'd2;
  localparam logic [3:0] OP_BLT  = 4'd3;
  localparam logic [3:0] OP_CBZ  = 4'd4;
  localparam logic [3:0] OP_LDUR = 4'd5;
  localparam logic [3:0] OP_LSL  = 4'd6;
  localparam logic [3:0] OP_LSR  = 4'd7;
  localparam logic [3:0] OP_MUL  = 4'd8;
  localparam logic [3:0] OP_STUR = 4'd9;
  localparam logic [3:0] OP_SUBS = 4'd10;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_OP   = 2'd1;
  localparam logic [1:0] ERR_IMM  = 2'd2;

  localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] DEPTH_W = ADDR_W'(DEPTH);
  localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(4);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q, count_q;
  logic              accept;
  logic [31:0]       enc_word;
  logic [1:0]        enc_code;
  logic              dt_imm_ok;   // 9-bit signed load/store offset
  logic              br_imm_ok;   // 19-bit signed conditional-branch offset

  // Upper bits must be a pure sign extension of the field's top bit.
  assign dt_imm_ok = (&imm[25:8])  | ~(|imm[25:8]);
  assign br_imm_ok = (&imm[25:18]) | ~(|imm[25:18]);

  // Encoder. A 6-bit shamt port cannot exceed 63, so no shamt error is
  // ever raised from this port width.
  always_comb begin
    enc_word = '0;
    enc_code = ERR_NONE;
    case (op)
      OP_ADDI: begin
        enc_word = {10'b1001000100, imm[11:0], rn, rd};
        if (|imm[25:12]) enc_code = ERR_IMM;
      end
      OP_ADDS: enc_word = {11'b10101011000, rm, 6'b000000, rn, rd};
      OP_SUBS: enc_word = {11'b11101011000, rm, 6'b000000, rn, rd};
      OP_LSL:  enc_word = {11'b11010011011, 5'b00000, shamt, rn, rd};
      OP_LSR:  enc_word = {11'b11010011010, 5'b00000, shamt, rn, rd};
      OP_MUL:  enc_word = {11'b10011011000, rm, 6'b011111, rn, rd};
      OP_LDUR: begin
        enc_word = {11'b11111000010, imm[8:0], 2'b00, rn, rd};
        if (!dt_imm_ok) enc_code = ERR_IMM;
      end
      OP_STUR: begin
        enc_word = {11'b11111000000, imm[8:0], 2'b00, rn, rd};
        if (!dt_imm_ok) enc_code = ERR_IMM;
      end
      OP_B:    enc_word = {6'b000101, imm};
      OP_CBZ: begin
        enc_word = {8'b10110100, imm[18:0], rd};
        if (!br_imm_ok) enc_code = ERR_IMM;
      end
      OP_BLT: begin
        enc_word = {8'b01010100, imm[18:0], 5'b01011};
        if (!br_imm_ok) enc_code = ERR_IMM;
      end
      default: enc_code = ERR_OP;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EMIT;
      EMIT:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    req_ready = 1'b0;
    if (state == IDLE) req_ready = !full && !clear;
  end

  assign accept = req_valid && req_ready;

  // Write/err outputs are registered at the accepting edge so they are
  // clean for the entire EMIT cycle; address and count advance at the
  // edge that closes EMIT, once the memory has taken the word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_en    <= 1'b0;
      wr_data  <= '0;
      err      <= 1'b0;
      err_code <= ERR_NONE;
      addr_q   <= BASE;
      count_q  <= '0;
    end else begin
      wr_en <= 1'b0;
      err   <= 1'b0;
      if (accept) begin
        if (enc_code == ERR_NONE) begin
          wr_en   <= 1'b1;
          wr_data <= enc_word;
        end else begin
          err      <= 1'b1;
          err_code <= enc_code;
        end
      end
      // clear overrides the post-write increment
      if (clear) begin
        addr_q  <= BASE;
        count_q <= '0;
      end else if (state == EMIT && wr_en) begin
        addr_q  <= addr_q + STEP;
        count_q <= count_q + 1'b1;
      end
    end
  end

  assign wr_addr = addr_q;
  assign count   = count_q;
  assign full    = (count_q == DEPTH_W);

endmodule

// File: tb/tb_legv8_insn_encoder.sv
module tb_legv8_insn_encoder;

  localparam int ADDR_W    = 5;
  localparam int DEPTH     = 4;
  localparam int BASE_ADDR = 24;   // first four writes wrap: 24, 28, 0, 4

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [3:0]        op = '0;
  logic [4:0]        rd = '0, rn = '0, rm = '0;
  logic [25:0]       imm = '0;
  logic [5:0]        shamt = '0;
  logic              clear = 1'b0;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              err;
  logic [1:0]        err_code;
  logic [ADDR_W-1:0] count;
  logic              full;

  int n_cmp = 0;
  int n_bad = 0;

  legv8_insn_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .op(op), .rd(rd), .rn(rn), .rm(rm), .imm(imm), .shamt(shamt), .clear(clear),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .err(err),
    .err_code(err_code), .count(count), .full(full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoding, built from opcode constants with arithmetic.
  function automatic logic [31:0] ref_enc(input int o, input int d, input int n, input int m,
                                          input int im, input int sh);
    int f;
    f = 0;
    case (o)
      0:  f = (32'h244 << 22) + ((im % 4096 + 4096) % 4096) * 1024 + n * 32 + d;
      1:  f = (32'h558 << 21) + m * 65536 + n * 32 + d;
      10: f = (32'h758 << 21) + m * 65536 + n * 32 + d;
      6:  f = (32'h69B << 21) + sh * 1024 + n * 32 + d;
      7:  f = (32'h69A << 21) + sh * 1024 + n * 32 + d;
      8:  f = (32'h4D8 << 21) + m * 65536 + 31 * 1024 + n * 32 + d;
      5:  f = (32'h7C2 << 21) + ((im % 512 + 512) % 512) * 4096 + n * 32 + d;
      9:  f = (32'h7C0 << 21) + ((im % 512 + 512) % 512) * 4096 + n * 32 + d;
      2:  f = (5 << 26) + ((im % 67108864 + 67108864) % 67108864);
      4:  f = (32'hB4 << 24) + ((im % 524288 + 524288) % 524288) * 32 + d;
      3:  f = (32'h54 << 24) + ((im % 524288 + 524288) % 524288) * 32 + 11;
      default: f = 0;
    endcase
    return 32'(f);
  endfunction

  // 0 legal, 1 illegal op, 2 immediate out of range.
  function automatic int ref_code(input int o, input logic [25:0] im_raw);
    int s;
    s = int'($signed(im_raw));
    if (o > 10) return 1;
    if (o == 0)            return (int'(im_raw) <= 4095) ? 0 : 2;
    if (o == 5 || o == 9)  return (s >= -256 && s <= 255) ? 0 : 2;
    if (o == 3 || o == 4)  return (s >= -262144 && s <= 262143) ? 0 : 2;
    return 0;
  endfunction

  // Behavioural model: one request in flight at most; outputs predicted
  // for the cycle after each rising edge.
  int          m_addr  = BASE_ADDR;
  int          m_count = 0;
  logic        m_wr    = 1'b0;
  logic        m_err   = 1'b0;
  int          m_code  = 0;
  logic [31:0] m_data  = '0;

  always @(negedge clk) begin
    logic busy, efull, eready;
    int   c;
    if (!reset_n) begin
      chk("rst_wr_en", 32'(wr_en), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_err_code", 32'(err_code), 0);
      chk("rst_wr_data", wr_data, 0);
      chk("rst_wr_addr", 32'(wr_addr), BASE_ADDR);
      chk("rst_count", 32'(count), 0);
      chk("rst_full", 32'(full), 0);
      m_addr = BASE_ADDR; m_count = 0; m_wr = 0; m_err = 0; m_code = 0; m_data = '0;
    end else begin
      busy   = m_wr || m_err;
      efull  = (m_count == DEPTH);
      eready = !busy && !efull && !clear;
      chk("req_ready", 32'(req_ready), 32'(eready));
      chk("wr_en", 32'(wr_en), 32'(m_wr));
      chk("err", 32'(err), 32'(m_err));
      chk("err_code", 32'(err_code), 32'(m_code));
      chk("wr_addr", 32'(wr_addr), 32'(m_addr % (1 << ADDR_W)));
      chk("count", 32'(count), 32'(m_count));
      chk("full", 32'(full), 32'(efull));
      if (m_wr) chk("wr_data", wr_data, m_data);
      // advance to the next edge
      if (busy) begin
        if (m_wr) begin m_addr = (m_addr + 4) % (1 << ADDR_W); m_count++; end
        if (clear) begin m_addr = BASE_ADDR; m_count = 0; end
        m_wr = 0; m_err = 0;
      end else if (clear) begin
        m_addr = BASE_ADDR; m_count = 0;
      end else if (req_valid && !efull) begin
        c = ref_code(int'(op), imm);
        if (c == 0) begin
          m_wr = 1;
          m_data = ref_enc(int'(op), int'(rd), int'(rn), int'(rm), int'($signed(imm)), int'(shamt));
        end else begin
          m_err = 1;
          m_code = c;
        end
      end
    end
  end

  task automatic drive(input int o, input int d, input int n, input int m, input int im, input int sh);
    op = 4'(o); rd = 5'(d); rn = 5'(n); rm = 5'(m); imm = 26'(im); shamt = 6'(sh);
  endtask

  // Wait (bounded) until the current request is taken; returns at the
  // accepting edge + 1.
  task automatic wait_accept(output bit ok);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: got req_ready=0 expected 1 within 50 cycles");
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // kind 0: expect a write of edata at eaddr; kind 1: expect err with ecode.
  task automatic issue(input int o, input int d, input int n, input int m, input int im,
                       input int sh, input int kind, input logic [31:0] edata,
                       input int eaddr, input int ecode);
    bit ok;
    @(posedge clk); #1;
    clear = 1'b0;
    drive(o, d, n, m, im, sh);
    req_valid = 1'b1;
    wait_accept(ok);
    @(negedge clk);
    if (kind == 0) begin
      chk("lit_wr_en", 32'(wr_en), 1);
      chk("lit_wr_data", wr_data, edata);
      chk("lit_wr_addr", 32'(wr_addr), 32'(eaddr));
    end else begin
      chk("lit_err", 32'(err), 1);
      chk("lit_wr_en_low", 32'(wr_en), 0);
      chk("lit_err_code", 32'(err_code), 32'(ecode));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int k;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 32'(req_ready), 1);

    issue(0, 1, 2, 0, 5, 0, 0, 32'h91001441, 24, 0);          // ADDI
    issue(10, 3, 4, 5, 0, 0, 0, 32'hEB050083, 28, 0);         // SUBS
    issue(2, 0, 0, 0, -1, 0, 0, 32'h17FFFFFF, 0, 0);          // B -1, address wraps
    issue(5, 9, 10, 0, -8, 0, 0, 32'hF85F8149, 4, 0);         // LDUR

    // full: request held but not taken
    @(posedge clk); #1;
    drive(0, 1, 1, 1, 1, 0);
    req_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("full_set", 32'(full), 1);
      chk("full_blocks_ready", 32'(req_ready), 0);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    clear = 1'b1;
    @(negedge clk);
    chk("clear_blocks_ready", 32'(req_ready), 0);
    @(posedge clk); #1;
    clear = 1'b0;
    @(negedge clk);
    chk("count_after_clear", 32'(count), 0);

    issue(3, 0, 0, 0, 3, 0, 0, 32'h5400006B, 24, 0);          // B.LT at base
    issue(5, 1, 1, 0, 256, 0, 1, 0, 0, 2);                    // LDUR imm too big
    issue(12, 1, 1, 1, 0, 0, 1, 0, 0, 1);                     // illegal op
    issue(0, 1, 1, 0, 4096, 0, 1, 0, 0, 2);                   // ADDI imm too big
    issue(4, 7, 0, 0, 262144, 0, 1, 0, 0, 2);                 // CBZ out of range
    issue(9, 2, 3, 0, -256, 0, 0, ref_enc(9, 2, 3, 0, -256, 0), 28, 0);

    // reset while emitting
    @(posedge clk); #1;
    drive(0, 1, 2, 0, 5, 0);
    req_valid = 1'b1;
    wait_accept(ok);
    reset_n = 1'b0;
    #1;
    chk("abort_wr_en", 32'(wr_en), 0);
    chk("abort_count", 32'(count), 0);
    chk("abort_wr_addr", 32'(wr_addr), BASE_ADDR);
    chk("abort_err_code", 32'(err_code), 0);
    @(posedge clk); #1 reset_n = 1'b1;
    issue(0, 1, 2, 0, 5, 0, 0, 32'h91001441, 24, 0);

    // randomized traffic checked by the model
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      req_valid = ($urandom_range(0, 2) != 0);
      clear     = ($urandom_range(0, 15) == 0);
      op = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(11, 15)) : 4'($urandom_range(0, 10));
      rd = 5'($urandom); rn = 5'($urandom); rm = 5'($urandom); shamt = 6'($urandom);
      k = $urandom_range(0, 3);
      case (k)
        0: imm = 26'($urandom);
        1: imm = 26'($urandom_range(0, 600) - 300);
        2: imm = 26'(((($urandom_range(0, 1)) != 0) ? 262144 : -262144) + $urandom_range(0, 6) - 3);
        default: imm = 26'($urandom_range(4090, 4100));
      endcase
    end
    @(posedge clk); #1;
    req_valid = 1'b0; clear = 1'b0;
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
